// File: rtl/fma_pkg.sv
// fma_pkg: shared types, depth constant and signed-range helpers
// for the fixed-point fused multiply-add pipeline.
package fma_pkg;

    localparam int PIPE_DEPTH = 3;

    typedef enum logic {
        FMA_MODE_FMA = 1'b0,
        FMA_MODE_ACC = 1'b1
    } fma_mode_e;

    typedef struct packed {
        fma_mode_e mode;
        logic      clr;
    } fma_ctl_t;

    function automatic logic [63:0] fma_smax(input int unsigned w);
        return (64'd1 << (w - 1)) - 64'd1;
    endfunction

    function automatic logic [63:0] fma_smin(input int unsigned w);
        return 64'd1 << (w - 1);
    endfunction

endpackage

// File: rtl/fma_mult_round.sv
// fma_mult_round: registered S2 signed multiply, round-half-up by Q,
// product overflow flag; clamps instead of wrapping under FMA_SAT_EN.
module fma_mult_round #(
    parameter int Q = 16,
    parameter int N = 32
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         en_i,
    input  logic         valid_i,
    input  logic [N-1:0] b_i,
    input  logic [N-1:0] c_i,
    output logic         valid_o,
    output logic [N-1:0] prod_o,
    output logic         ovf_o
);
    import fma_pkg::*;

    localparam logic signed [2*N-1:0] RND =
        {{(2*N-1){1'b0}}, 1'b1} << (Q - 1);
`ifdef FMA_SAT_EN
    localparam logic [63:0] MAX64 = fma_smax(N);
    localparam logic [63:0] MIN64 = fma_smin(N);
    localparam logic [N-1:0] SMAX = MAX64[N-1:0];
    localparam logic [N-1:0] SMIN = MIN64[N-1:0];
`endif

    logic signed [2*N-1:0] bx, cx, full, rnd, sh;
    logic [N-1:0] prod_d, prod_q;
    logic ovf_d, ovf_q, valid_q;

    always_comb begin
        bx = {{N{b_i[N-1]}}, b_i};
        cx = {{N{c_i[N-1]}}, c_i};
        full = bx * cx;
        rnd = full + RND;
        sh = rnd >>> Q;
        // fits in N bits only if all bits above the sign match it
        ovf_d = sh[2*N-1:N-1] != {(N+1){sh[N-1]}};
`ifdef FMA_SAT_EN
        prod_d = ovf_d ? (sh[2*N-1] ? SMIN : SMAX) : sh[N-1:0];
`else
        prod_d = sh[N-1:0];
`endif
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            valid_q <= 1'b0;
            prod_q  <= '0;
            ovf_q   <= 1'b0;
        end else if (en_i) begin
            valid_q <= valid_i;
            if (valid_i) begin
                prod_q <= prod_d;
                ovf_q  <= ovf_d;
            end
        end
    end

    assign valid_o = valid_q;
    assign prod_o  = prod_q;
    assign ovf_o   = ovf_q;

endmodule

// File: rtl/fma_pipe.sv
// fma_pipe: 3-stage streaming a+b*c / acc+b*c in signed Q format with
// valid/ready flow control; FMA_SAT_EN selects saturating arithmetic.
module fma_pipe #(
    parameter int Q = 16,
    parameter int N = 32
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [N-1:0] in_a,
    input  logic [N-1:0] in_b,
    input  logic [N-1:0] in_c,
    input  logic         in_mode,
    input  logic         in_acc_clr,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [N-1:0] out_result,
    output logic         out_ovf
);
    import fma_pkg::*;

`ifdef FMA_SAT_EN
    localparam logic [63:0] MAX64 = fma_smax(N);
    localparam logic [63:0] MIN64 = fma_smin(N);
    localparam logic [N-1:0] SMAX = MAX64[N-1:0];
    localparam logic [N-1:0] SMIN = MIN64[N-1:0];
`endif

    logic advance;
    logic s1_valid_q;
    logic [N-1:0] s1_a_q, s1_b_q, s1_c_q;
    fma_ctl_t s1_ctl_q;
    logic s2_valid, s2_povf;
    logic [N-1:0] s2_a_q, s2_prod;
    fma_ctl_t s2_ctl_q;
    logic [N-1:0] acc_q, addend, res_d;
    logic [N:0] sum;
    logic sovf, ovf_d;
    logic out_valid_q, out_ovf_q;
    logic [N-1:0] out_result_q;

    assign advance  = !out_valid_q || out_ready;
    assign in_ready = advance;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            s1_valid_q <= 1'b0;
            s1_a_q     <= '0;
            s1_b_q     <= '0;
            s1_c_q     <= '0;
            s1_ctl_q   <= '{mode: FMA_MODE_FMA, clr: 1'b0};
        end else if (advance) begin
            s1_valid_q <= in_valid;
            if (in_valid) begin
                s1_a_q   <= in_a;
                s1_b_q   <= in_b;
                s1_c_q   <= in_c;
                s1_ctl_q <= '{mode: fma_mode_e'(in_mode), clr: in_acc_clr};
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            s2_a_q   <= '0;
            s2_ctl_q <= '{mode: FMA_MODE_FMA, clr: 1'b0};
        end else if (advance && s1_valid_q) begin
            s2_a_q   <= s1_a_q;
            s2_ctl_q <= s1_ctl_q;
        end
    end

    fma_mult_round #(.Q(Q), .N(N)) u_mult (
        .clk     (clk),
        .rst_n   (rst_n),
        .en_i    (advance),
        .valid_i (s1_valid_q),
        .b_i     (s1_b_q),
        .c_i     (s1_c_q),
        .valid_o (s2_valid),
        .prod_o  (s2_prod),
        .ovf_o   (s2_povf)
    );

    always_comb begin
        addend = s2_a_q;
        if (s2_ctl_q.mode == FMA_MODE_ACC) begin
            addend = s2_ctl_q.clr ? '0 : acc_q;
        end
        sum = {addend[N-1], addend} + {s2_prod[N-1], s2_prod};
        sovf = sum[N] ^ sum[N-1];
`ifdef FMA_SAT_EN
        res_d = sovf ? (sum[N] ? SMIN : SMAX) : sum[N-1:0];
`else
        res_d = sum[N-1:0];
`endif
        ovf_d = s2_povf | sovf;
    end

    // acc is read and written here, so accumulates chain without bubbles
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            out_valid_q  <= 1'b0;
            out_result_q <= '0;
            out_ovf_q    <= 1'b0;
            acc_q        <= '0;
        end else if (advance) begin
            out_valid_q <= s2_valid;
            if (s2_valid) begin
                out_result_q <= res_d;
                out_ovf_q    <= ovf_d;
                if (s2_ctl_q.mode == FMA_MODE_ACC) begin
                    acc_q <= res_d;
                end
            end
        end
    end

    assign out_valid  = out_valid_q;
    assign out_result = out_result_q;
    assign out_ovf    = out_ovf_q;

endmodule

// File: tb/tb_fma_pipe.sv
// tb_fma_pipe: table vectors, hand-written handshake/reset sequences and
// randomized traffic against an integer reference model of fma_pipe.
module tb_fma_pipe;
    import fma_pkg::*;

    localparam int Q = 16;
    localparam int N = 32;
    localparam longint HI = 64'sh7FFF_FFFF;
    localparam longint LO = -64'sh8000_0000;

    logic clk, rst_n, in_valid, in_ready, in_mode, in_acc_clr;
    logic out_valid, out_ready, out_ovf;
    logic [N-1:0] in_a, in_b, in_c, out_result;

    typedef struct {
        logic [31:0] a, b, c;
        logic mode, clr;
        logic [31:0] res;
        logic ovf;
    } vec_t;

    typedef struct {
        logic [31:0] res;
        logic ovf;
        int tag;
    } exp_t;

    exp_t exp_q[$];
    vec_t tbl[10];
    int checks = 0;
    int failures = 0;
    int tag_n = 0;
    bit rand_rdy = 0;
    longint macc = 0;

    fma_pipe #(.Q(Q), .N(N)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_a       (in_a),
        .in_b       (in_b),
        .in_c       (in_c),
        .in_mode    (in_mode),
        .in_acc_clr (in_acc_clr),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_result (out_result),
        .out_ovf    (out_ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", nm, act, req);
        end
    endtask

    // Reference: plain integer arithmetic on signed values
    function automatic void model(input logic [31:0] a, b, c,
                                  input logic mode, clr,
                                  output logic [31:0] res,
                                  output logic ovf);
        longint p, ad, s;
        bit pov, sov;
        p = (longint'($signed(b)) * longint'($signed(c)) + 64'sd32768) >>> 16;
        pov = (p > HI) || (p < LO);
`ifdef FMA_SAT_EN
        if (p > HI) p = HI;
        else if (p < LO) p = LO;
`else
        p = longint'($signed(p[31:0]));
`endif
        ad = mode ? (clr ? 64'sd0 : macc) : longint'($signed(a));
        s = ad + p;
        sov = (s > HI) || (s < LO);
`ifdef FMA_SAT_EN
        if (s > HI) s = HI;
        else if (s < LO) s = LO;
`else
        s = longint'($signed(s[31:0]));
`endif
        res = s[31:0];
        ovf = pov | sov;
        if (mode) macc = s;
    endfunction

    task automatic send(input logic [31:0] a, b, c, input logic mode, clr,
                        input bit use_c, input logic [31:0] eres,
                        input logic eovf);
        logic [31:0] r;
        logic o;
        @(negedge clk);
        in_a = a; in_b = b; in_c = c;
        in_mode = mode; in_acc_clr = clr; in_valid = 1'b1;
        #1;
        for (int i = 0; i < 64 && !in_ready; i++) begin
            @(negedge clk);
            #1;
        end
        if (!in_ready) begin
            chk("accept_timeout", {31'd0, in_ready}, 32'd1);
            in_valid = 1'b0;
        end else begin
            model(a, b, c, mode, clr, r, o);
            exp_q.push_back('{res: use_c ? eres : r,
                              ovf: use_c ? eovf : o, tag: tag_n});
            tag_n++;
        end
    endtask

    task automatic drain();
        for (int i = 0; i < 300 && exp_q.size() != 0; i++) @(negedge clk);
        chk("drain_empty", exp_q.size(), 0);
    endtask

    function automatic logic [31:0] rnd_op();
        logic [31:0] v;
        if ($urandom_range(0, 3) == 0) return $urandom();
        v = $urandom_range(0, 32'h7FFFF);
        return v - 32'h40000;
    endfunction

    always begin
        @(negedge clk);
        if (rand_rdy) out_ready = ($urandom_range(0, 3) != 0);
    end

    exp_t e;
    always begin
        @(negedge clk);
        #2;
        if (rst_n && out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_out", {31'd0, out_valid}, 32'd0);
            end else begin
                e = exp_q.pop_front();
                chk($sformatf("result#%0d", e.tag), out_result, e.res);
                chk($sformatf("ovf#%0d", e.tag), {31'd0, out_ovf},
                    {31'd0, e.ovf});
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog expired");
        $fatal(1, "timeout");
    end

    initial begin
        logic [31:0] held;
        int n;
        logic [31:0] bp[5];

        tbl[0] = '{32'h00004000, 32'h00018000, 32'h00020000, 0, 0, 32'h00034000, 0};
        tbl[1] = '{32'h0, 32'h00000001, 32'h00008000, 0, 0, 32'h00000001, 0};
        tbl[2] = '{32'h0, 32'hFFFFFFFF, 32'h00008000, 0, 0, 32'h00000000, 0};
        tbl[4] = '{32'h0, 32'hFFFF0000, 32'h00020000, 0, 0, 32'hFFFE0000, 0};
        tbl[9] = '{32'h00010000, 32'h0, 32'h0, 0, 1, 32'h00010000, 0};
`ifdef FMA_SAT_EN
        tbl[3] = '{32'h0, 32'h7FFF0000, 32'h7FFF0000, 0, 0, 32'h7FFFFFFF, 1};
        tbl[5] = '{32'h7FFFFFFF, 32'h00010000, 32'h00010000, 0, 0, 32'h7FFFFFFF, 1};
        tbl[6] = '{32'h0, 32'h80000000, 32'h80000000, 0, 0, 32'h7FFFFFFF, 1};
        tbl[7] = '{32'h80000000, 32'hFFFF0000, 32'h00010000, 0, 0, 32'h80000000, 1};
        tbl[8] = '{32'h0, 32'h80000000, 32'h00020000, 0, 0, 32'h80000000, 1};
`else
        tbl[3] = '{32'h0, 32'h7FFF0000, 32'h7FFF0000, 0, 0, 32'h00010000, 1};
        tbl[5] = '{32'h7FFFFFFF, 32'h00010000, 32'h00010000, 0, 0, 32'h8000FFFF, 1};
        tbl[6] = '{32'h0, 32'h80000000, 32'h80000000, 0, 0, 32'h00000000, 1};
        tbl[7] = '{32'h80000000, 32'hFFFF0000, 32'h00010000, 0, 0, 32'h7FFF0000, 1};
        tbl[8] = '{32'h0, 32'h80000000, 32'h00020000, 0, 0, 32'h00000000, 1};
`endif

        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        in_a = '0; in_b = '0; in_c = '0; in_mode = 1'b0; in_acc_clr = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_out_result", out_result, 32'd0);
        chk("rst_out_ovf", {31'd0, out_ovf}, 32'd0);
        chk("rst_in_ready", {31'd0, in_ready}, 32'd1);

        // Latency of the basic FMA beat
        send(tbl[0].a, tbl[0].b, tbl[0].c, 0, 0, 1, tbl[0].res, tbl[0].ovf);
        for (int k = 1; k <= PIPE_DEPTH; k++) begin
            @(posedge clk);
            #1;
            in_valid = 1'b0;
            chk($sformatf("latency_edge%0d", k), {31'd0, out_valid},
                {31'd0, k == PIPE_DEPTH});
        end
        drain();

        for (int i = 0; i < 10; i++) begin
            send(tbl[i].a, tbl[i].b, tbl[i].c, tbl[i].mode, tbl[i].clr,
                 1, tbl[i].res, tbl[i].ovf);
        end
        @(negedge clk);
        in_valid = 1'b0;
        drain();

        // Back-to-back accumulate: results on consecutive cycles
        send(0, 32'h00010000, 32'h00008000, 1, 1, 1, 32'h00008000, 0);
        send(0, 32'h00010000, 32'h00008000, 1, 0, 1, 32'h00010000, 0);
        send(0, 32'h00010000, 32'h00008000, 1, 0, 1, 32'h00018000, 0);
        send(0, 32'h00010000, 32'h00008000, 1, 0, 1, 32'h00020000, 0);
        for (int k = 0; k < 4; k++) begin
            chk($sformatf("acc_stream%0d", k), {31'd0, out_valid}, 32'd1);
            @(negedge clk);
            in_valid = 1'b0;
            #1;
        end
        chk("acc_stream_end", {31'd0, out_valid}, 32'd0);
        drain();

        // Backpressure: out_ready low for 6 cycles, 5 beats offered
        for (int i = 0; i < 5; i++) bp[i] = rnd_op();
        n = 0;
        held = '0;
        for (int cyc = 0; cyc < 30 && n < 5; cyc++) begin
            @(negedge clk);
            out_ready = (cyc >= 6);
            in_a = bp[n]; in_b = bp[(n + 1) % 5]; in_c = bp[(n + 2) % 5];
            in_mode = 1'b0; in_acc_clr = 1'b0; in_valid = 1'b1;
            #1;
            if (cyc == 3) held = out_result;
            if (cyc == 5) begin
                chk("bp_accepted", n, 3);
                chk("bp_in_ready", {31'd0, in_ready}, 32'd0);
                chk("bp_out_valid", {31'd0, out_valid}, 32'd1);
                chk("bp_hold", out_result, held);
            end
            if (in_ready) begin
                logic [31:0] r;
                logic o;
                model(in_a, in_b, in_c, 0, 0, r, o);
                exp_q.push_back('{res: r, ovf: o, tag: tag_n});
                tag_n++;
                n++;
            end
        end
        @(negedge clk);
        in_valid = 1'b0;
        chk("bp_all_accepted", n, 5);
        drain();

        // Reset with two accumulate beats in flight
        send(0, 32'h00020000, 32'h00010000, 1, 0, 0, 0, 0);
        send(0, 32'h00020000, 32'h00010000, 1, 0, 0, 0, 0);
        @(negedge clk);
        in_valid = 1'b0;
        rst_n = 1'b0;
        exp_q.delete();
        macc = 0;
        @(negedge clk);
        rst_n = 1'b1;
        for (int k = 0; k < 5; k++) begin
            #1;
            chk($sformatf("mid_rst_idle%0d", k), {31'd0, out_valid}, 32'd0);
            @(negedge clk);
        end
        chk("mid_rst_result", out_result, 32'd0);
        send(0, 32'h00010000, 32'h00008000, 1, 0, 1, 32'h00008000, 0);
        @(negedge clk);
        in_valid = 1'b0;
        drain();

        // Randomized traffic with random backpressure
        rand_rdy = 1'b1;
        for (int i = 0; i < 300; i++) begin
            if ($urandom_range(0, 4) == 0) begin
                @(negedge clk);
                in_valid = 1'b0;
            end else begin
                send(rnd_op(), rnd_op(), rnd_op(), 1'($urandom_range(0, 1)),
                     1'($urandom_range(0, 3) == 0), 0, 0, 0);
            end
        end
        @(negedge clk);
        in_valid = 1'b0;
        rand_rdy = 1'b0;
        out_ready = 1'b1;
        drain();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
